generic_sram_line_en_arb: RTL and testbench

- Round-robin arbiter that shares one single-port line-enable SRAM between N_REQ requesters.
- Each requester presents word-wide read or write requests on a valid/ready handshake.
- The block drives the SRAM port directly and returns read data one cycle after acceptance, with a per-requester response strobe.
- It sits between bus-side agents (e.g. CPU fetch, DMA) and the SRAM wrapper.

---
 rtl/generic_sram_arb_pkg.sv | 24 ++
 rtl/generic_sram_line_en_arb_rr_arb_select.sv | 34 +++
 rtl/generic_sram_line_en_arb.sv | 116 +++++++++++
 tb/tb_generic_sram_line_en_arb.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_sram_arb_pkg.sv
// Shared types and constants for the round-robin SRAM port arbiter.
// Requester IDs are sized for the largest supported requester count (8).
package generic_sram_arb_pkg;

    localparam int MAX_REQ = 8;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    localparam int ID_W = id_width(MAX_REQ);

    typedef logic [ID_W-1:0] rsp_id_t;

    typedef struct packed {
        logic    active;
        rsp_id_t owner;
    } lock_t;

    localparam rsp_id_t ID_ZERO   = {ID_W{1'b0}};
    localparam rsp_id_t ID_ONE    = {{(ID_W-1){1'b0}}, 1'b1};
    localparam lock_t   LOCK_NONE = '{active: 1'b0, owner: {ID_W{1'b0}}};

endpackage

// File: rtl/generic_sram_line_en_arb_rr_arb_select.sv
// Combinational round-robin pick: first set request bit at or above prio_ptr,
// wrapping modulo N_REQ. prio_ptr must be below N_REQ.
module rr_arb_select
    import generic_sram_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  rsp_id_t          prio_ptr,
    output logic [N_REQ-1:0] grant,
    output rsp_id_t          grant_idx,
    output logic             any_grant
);

    // Rotate so prio_ptr sits at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        int                 sel;
        logic [N_REQ-1:0]   rot;
        rot       = N_REQ'({req, req} >> prio_ptr);
        sel       = 0;
        any_grant = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sel       = rot[i] ? i : sel;
            any_grant = any_grant | rot[i];
        end
        sel       = sel + int'(prio_ptr);
        sel       = (sel >= N_REQ) ? (sel - N_REQ) : sel;
        grant_idx = rsp_id_t'(sel);
        for (int j = 0; j < N_REQ; j++) begin
            grant[j] = any_grant && (j == sel);
        end
    end

endmodule

// File: rtl/generic_sram_line_en_arb.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between N_REQ
// requesters, with grant locking and a one-cycle response strobe per beat.
module generic_sram_line_en_arb
    import generic_sram_arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic [N_REQ-1:0]               i_req_valid,
    output logic [N_REQ-1:0]               o_req_ready,
    input  logic [N_REQ-1:0]               i_req_write,
    input  logic [N_REQ-1:0]               i_req_lock,
    input  logic [N_REQ*MEM_ADDR_BITS-1:0] i_req_addr,
    input  logic [N_REQ*MEM_DATA_BITS-1:0] i_req_wdata,
    output logic [N_REQ-1:0]               o_rsp_valid,
    output logic [MEM_DATA_BITS-1:0]       o_rsp_rdata,
    output logic [MEM_ADDR_BITS-1:0]       o_sram_addr,
    output logic                           o_sram_write_en,
    output logic [MEM_DATA_BITS-1:0]       o_sram_write_data,
    input  logic [MEM_DATA_BITS-1:0]       i_sram_read_data
);

    localparam rsp_id_t LAST_ID = rsp_id_t'(N_REQ - 1);

    lock_t              lock_r;
    lock_t              lock_nxt_s;
    rsp_id_t            prio_ptr_r;
    rsp_id_t            prio_ptr_nxt_s;
    rsp_id_t            ptr_inc_s;
    rsp_id_t            rsp_id_r;
    logic               rsp_valid_r;

    logic [N_REQ-1:0]   lock_mask_s;
    logic [N_REQ-1:0]   elig_s;
    logic [N_REQ-1:0]   grant_s;
    rsp_id_t            grant_idx_s;
    logic               any_grant_s;

    logic [MEM_ADDR_BITS-1:0] sel_addr_s;
    logic [MEM_DATA_BITS-1:0] sel_wdata_s;
    logic                     sel_write_s;
    logic                     sel_lock_s;

    // A held lock restricts eligibility to its owner, even while the owner is idle.
    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            lock_mask_s[j] = (lock_r.owner == rsp_id_t'(j));
        end
        elig_s = lock_r.active ? (i_req_valid & lock_mask_s) : i_req_valid;
    end

    rr_arb_select #(
        .N_REQ (N_REQ)
    ) u_rr_arb_select (
        .req       (elig_s),
        .prio_ptr  (prio_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any_grant (any_grant_s)
    );

    assign o_req_ready = grant_s;

    // Route the granted requester's beat to the SRAM; everything is zero when idle.
    always_comb begin
        sel_addr_s  = {MEM_ADDR_BITS{1'b0}};
        sel_wdata_s = {MEM_DATA_BITS{1'b0}};
        sel_write_s = 1'b0;
        sel_lock_s  = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            sel_addr_s  = grant_s[j] ? i_req_addr[j*MEM_ADDR_BITS +: MEM_ADDR_BITS]  : sel_addr_s;
            sel_wdata_s = grant_s[j] ? i_req_wdata[j*MEM_DATA_BITS +: MEM_DATA_BITS] : sel_wdata_s;
            sel_write_s = grant_s[j] ? i_req_write[j] : sel_write_s;
            sel_lock_s  = grant_s[j] ? i_req_lock[j]  : sel_lock_s;
        end
        o_sram_addr       = sel_addr_s;
        o_sram_write_en   = sel_write_s;
        o_sram_write_data = sel_wdata_s;
    end

    // A locked beat keeps the pointer so the owner resumes at the same priority.
    always_comb begin
        ptr_inc_s      = (grant_idx_s == LAST_ID) ? ID_ZERO : (grant_idx_s + ID_ONE);
        prio_ptr_nxt_s = (any_grant_s && !sel_lock_s) ? ptr_inc_s : prio_ptr_r;
        lock_nxt_s     = any_grant_s
                       ? (sel_lock_s ? lock_t'{active: 1'b1, owner: grant_idx_s} : LOCK_NONE)
                       : lock_r;
    end

    // Pointer, lock and response pipeline registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            prio_ptr_r  <= ID_ZERO;
            lock_r      <= LOCK_NONE;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= ID_ZERO;
        end else begin
            prio_ptr_r  <= prio_ptr_nxt_s;
            lock_r      <= lock_nxt_s;
            rsp_valid_r <= any_grant_s;
            rsp_id_r    <= grant_idx_s;
        end
    end

    // Response strobe decode; read data comes straight from the SRAM.
    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            o_rsp_valid[j] = rsp_valid_r && (rsp_id_r == rsp_id_t'(j));
        end
        o_rsp_rdata = i_sram_read_data;
    end

endmodule

// File: tb/tb_generic_sram_line_en_arb.sv
// Scoreboard bench for generic_sram_line_en_arb (N_REQ=4): directed scenarios
// plus constrained-random traffic against a behavioural arbitration/memory model.
module tb_generic_sram_line_en_arb;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_write, req_lock, req_ready, rsp_valid;
    logic [AW-1:0]   addr_a  [N];
    logic [DW-1:0]   wdata_a [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, sram_wd, sram_rd;
    logic [AW-1:0]   sram_addr;
    logic            sram_we;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            req_addr[k*AW +: AW]  = addr_a[k];
            req_wdata[k*DW +: DW] = wdata_a[k];
        end
    end

    generic_sram_line_en_arb #(
        .N_REQ(N), .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)
    ) dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_req_valid       (req_valid),
        .o_req_ready       (req_ready),
        .i_req_write       (req_write),
        .i_req_lock        (req_lock),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_rsp_valid       (rsp_valid),
        .o_rsp_rdata       (rsp_rdata),
        .o_sram_addr       (sram_addr),
        .o_sram_write_en   (sram_we),
        .o_sram_write_data (sram_wd),
        .i_sram_read_data  (sram_rd)
    );

    // Behavioural synchronous single-port SRAM attached to the DUT.
    logic [DW-1:0] smem [1024] = '{default: 32'h0};
    always @(posedge clk) begin
        if (sram_we) smem[sram_addr] <= sram_wd;
        sram_rd <= smem[sram_addr];
    end

    typedef struct {
        int            due;
        int            id;
        bit            is_read;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    exp_t          e_push, e_pop;
    logic [DW-1:0] ref_mem [1024] = '{default: 32'h0};
    int            cyc = 0;
    int            ref_ptr = 0;
    int            ref_owner = -1;
    int            last_grant = -1;
    int            g_model;
    int            checks = 0;
    int            errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level arbitration rule: lock owner only, else first valid from the pointer.
    function automatic int ref_pick();
        if (ref_owner >= 0) return req_valid[ref_owner] ? ref_owner : -1;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ref_ptr + i) % N;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) return i;
        return -1;
    endfunction

    // Reference model: check the request side and push expected responses.
    always @(negedge clk) begin
        if (!rstn) begin
            ref_ptr    = 0;
            ref_owner  = -1;
            last_grant = -1;
            q.delete();
        end else begin
            g_model = ref_pick();
            check("ready", req_ready, (g_model >= 0) ? (64'd1 << g_model) : 64'd0);
            if (g_model >= 0) begin
                check("sram_addr", sram_addr, addr_a[g_model]);
                check("sram_we", sram_we, req_write[g_model]);
                if (req_write[g_model]) check("sram_wdata", sram_wd, wdata_a[g_model]);
                e_push.due     = cyc + 1;
                e_push.id      = g_model;
                e_push.is_read = !req_write[g_model];
                e_push.data    = ref_mem[addr_a[g_model]];
                q.push_back(e_push);
                if (req_write[g_model]) ref_mem[addr_a[g_model]] = wdata_a[g_model];
                if (req_lock[g_model]) begin
                    ref_owner = g_model;
                end else begin
                    ref_owner = -1;
                    ref_ptr   = (g_model + 1) % N;
                end
            end else begin
                check("sram_idle", {sram_we, sram_addr}, 64'd0);
            end
            last_grant = g_model;
        end
    end

    // Response monitor: pops the scoreboard whenever a response is due or seen.
    always @(negedge clk) begin
        if (!rstn) begin
            check("rsp_in_reset", rsp_valid, 64'd0);
        end else if (rsp_valid != '0) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                check("rsp_unexpected", rsp_valid, 64'd0);
            end else begin
                e_pop = q.pop_front();
                check("rsp_id", rsp_valid, 64'd1 << e_pop.id);
                if (e_pop.is_read) check("rsp_rdata", rsp_rdata, e_pop.data);
            end
        end else if (q.size() != 0 && q[0].due == cyc) begin
            e_pop = q.pop_front();
            check("rsp_missing", rsp_valid, 64'd1 << e_pop.id);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_lock  = '0;
        for (int k = 0; k < N; k++) begin
            addr_a[k]  = '0;
            wdata_a[k] = '0;
        end
    endtask

    task automatic set_req(input int k, input bit w, input bit l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_lock[k]  = l;
        addr_a[k]    = a;
        wdata_a[k]   = d;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_reqs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        clear_reqs();
        tick();
        at_neg();
        check("reset_rsp_valid", rsp_valid, 64'd0);
        check("reset_sram_we", sram_we, 64'd0);
        tick();
        rstn = 1'b1;

        // Single read of a preloaded word (preload goes through the arbiter).
        set_req(0, 1'b1, 1'b0, 10'd5, 32'hDEADBEEF);
        tick();
        clear_reqs();
        set_req(0, 1'b0, 1'b0, 10'd5, 32'h0);
        at_neg();
        check("read_ready0", req_ready, 64'b0001);
        tick();
        clear_reqs();
        at_neg();
        check("read_rsp_valid", rsp_valid, 64'b0001);
        check("read_rdata", rsp_rdata, 64'hDEADBEEF);
        tick();

        // Contention: two continuous readers alternate from a fresh pointer.
        do_reset();
        set_req(0, 1'b0, 1'b0, 10'd1, 32'h0);
        set_req(1, 1'b0, 1'b0, 10'd2, 32'h0);
        for (int i = 0; i < 6; i++) begin
            at_neg();
            check("contention_grant", onehot_idx(req_ready), i % 2);
            tick();
        end
        clear_reqs();

        // Write then read back-to-back from the same requester.
        set_req(0, 1'b1, 1'b0, 10'd3, 32'h12345678);
        at_neg();
        check("wr_we_high", sram_we, 64'd1);
        tick();
        clear_reqs();
        set_req(0, 1'b0, 1'b0, 10'd3, 32'h0);
        at_neg();
        check("rd_we_low", sram_we, 64'd0);
        check("wr_ack", rsp_valid, 64'b0001);
        tick();
        clear_reqs();
        at_neg();
        check("raw_rdata", rsp_rdata, 64'h12345678);
        tick();

        // Lock: requester 1 runs three beats (lock 1,1,0) while requester 0 waits.
        set_req(1, 1'b0, 1'b1, 10'd10, 32'h0);
        at_neg();
        check("lock_beat1", req_ready, 64'b0010);
        tick();
        set_req(0, 1'b0, 1'b0, 10'd11, 32'h0);
        set_req(1, 1'b1, 1'b1, 10'd12, 32'hCAFE0001);
        at_neg();
        check("lock_beat2", req_ready, 64'b0010);
        tick();
        set_req(1, 1'b0, 1'b0, 10'd12, 32'h0);
        at_neg();
        check("lock_beat3", req_ready, 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        at_neg();
        check("lock_release", req_ready, 64'b0001);
        tick();
        clear_reqs();

        // Reset the cycle after a locked read is accepted.
        set_req(2, 1'b0, 1'b1, 10'd20, 32'h0);
        at_neg();
        check("rst_accept", req_ready, 64'b0100);
        tick();
        check("rst_rsp_before", rsp_valid, 64'b0100);
        rstn = 1'b0;
        clear_reqs();
        #1;
        check("rst_rsp_immediate", rsp_valid, 64'd0);
        tick();
        tick();
        check("rst_rsp_held", rsp_valid, 64'd0);
        rstn = 1'b1;
        set_req(0, 1'b0, 1'b0, 10'd21, 32'h0);
        set_req(2, 1'b0, 1'b0, 10'd22, 32'h0);
        at_neg();
        check("rst_first_grant", req_ready, 64'b0001);
        tick();
        clear_reqs();

        // Pointer wrap with all four requesters valid.
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 1'b0, AW'(k + 30), 32'h0);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("wrap_grant", onehot_idx(req_ready), i % N);
            tick();
        end
        clear_reqs();
        tick();

        // Random traffic; pending requests are held until granted.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] || last_grant == k) begin
                    req_valid[k] = (ref_owner == k) || ($urandom_range(0, 2) != 0);
                    req_write[k] = 1'($urandom_range(0, 1));
                    req_lock[k]  = ($urandom_range(0, 3) == 0);
                    addr_a[k]    = AW'($urandom_range(0, 15));
                    wdata_a[k]   = $urandom;
                end
            end
            tick();
        end
        clear_reqs();
        repeat (3) tick();
        check("drain_empty", q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
